uart_buffered_loopback: RTL and testbench
=========================================

// Module: uart_buffered_loopback
// PURPOSE
//  Parametrised UART echo block: deserialises frames on i_uart_rx, checks parity/stop, queues good
//  characters in an internal FIFO, reserialises them on o_uart_tx in arrival order. Successor to
//  the fixed 8N1 unbuffered loopback top; adds width/parity/stop config, buffering, TX hold, error flags.
// PARAMETERS
//  CLKS_PER_BIT  217  i_clk cycles per bit (25 MHz / 115200); >= 4
//  DATA_BITS     8    data bits per frame, 5..9, LSB first
//  PARITY        0    0 none, 1 odd, 2 even
//  STOP_BITS     1    1 or 2
//  FIFO_DEPTH    16   entries, power of 2, >= 2
// PORTS
//  i_clk         in   1                 system clock
//  i_reset       in   1                 synchronous, active-high reset
//  i_uart_rx     in   1                 async serial in, idle high
//  o_uart_tx     out  1                 serial out, idle high
//  i_tx_enable   in   1                 1: TX may start a new frame; 0: hold (current frame finishes)
//  i_clear_err   in   1                 1-cycle pulse clears all sticky error flags
//  o_fifo_count  out  $clog2(DEPTH)+1   entries currently queued
//  o_overflow    out  1                 sticky: good char dropped because FIFO full
//  o_parity_err  out  1                 sticky: parity mismatch seen
//  o_frame_err   out  1                 sticky: stop bit sampled low
// BEHAVIOUR
//  Reset (sync, one edge): o_uart_tx=1, o_fifo_count=0, all flags 0, RX/TX FSMs IDLE, FIFO pointers 0.
//   Reset mid-frame aborts both FSMs; o_uart_tx high from the edge after reset sampled.
//  RX sync: i_uart_rx through 2-flop synchroniser; all RX decisions use the synchronised bit.
//  RX FSM: IDLE -> START on synced 1->0. START: count CLKS_PER_BIT/2; if line still 0 -> DATA,
//   else -> IDLE (glitch reject, no flag). DATA: sample every CLKS_PER_BIT, DATA_BITS samples,
//   shift LSB first. PARITY (skipped if PARITY=0): one sample, compare. STOP: STOP_BITS samples
//   spaced CLKS_PER_BIT; any 0 -> frame error. DONE: one cycle, then IDLE.
//  DONE action: frame err -> set o_frame_err, discard; else parity err -> set o_parity_err, discard;
//   else push to FIFO if not full, else set o_overflow and discard. Frame error has priority.
//  RX returns to IDLE right after last stop sample (mid-bit), so back-to-back frames are received.
//  FIFO: push in DONE cycle; count updates the following edge. Push and pop same cycle: count
//   unchanged, both succeed, including when full (pop frees slot) and when empty only if push precedes
//   (pop never occurs on empty). Pointers wrap modulo FIFO_DEPTH.
//  TX FSM: IDLE -> LOAD when FIFO non-empty and i_tx_enable=1; LOAD pops one entry (1 cycle) ->
//   START (o_uart_tx=0, CLKS_PER_BIT) -> DATA (DATA_BITS x CLKS_PER_BIT, LSB first) -> PARITY
//   (if enabled) -> STOP (STOP_BITS x CLKS_PER_BIT, high) -> IDLE.
//  Latency: o_uart_tx falls on the 2nd rising edge after the FIFO-write edge when TX idle and enabled.
//  Gap between queued frames: exactly 2 cycles of idle-high (IDLE + LOAD) after final stop bit.
//  i_tx_enable deassert mid-frame: frame completes; no new LOAD until reasserted.
//  Parity: odd => data^par has odd number of 1s; even => even. Same rule for TX generation.
//  i_clear_err clears flags; if a new error sets in the same cycle, set wins.
// TESTING (CLKS_PER_BIT=8 unless noted)
//  8N1, send 0x53 -> identical 0x53 frame on o_uart_tx, start bit 2 cycles after push; count 1->0.
//  Send 0x53,0x61,0xA5,0x0F back-to-back -> echoed same order, 2-cycle gaps, no flags set.
//  FIFO_DEPTH=4, i_tx_enable=0, send 6 chars -> count=4, o_overflow=1; enable -> first 4 echoed only.
//  PARITY=2, send 0x53 with parity bit 1 -> not echoed, o_parity_err=1; i_clear_err -> 0.
//  Stop bit forced 0 on 0x61 -> o_frame_err=1, nothing queued; 3-cycle low glitch -> ignored.
//  Assert i_reset mid-TX data bit -> o_uart_tx=1 next edge, count=0, next 0x53 echoes cleanly.

Source files
------------

// File: rtl/uart_buffered_loopback_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_buffered_loopback_if                                       |
// | Purpose  : Serial lines, TX hold/clear controls and status of the echo.    |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface uart_buffered_loopback_if #(
  parameter int FIFO_DEPTH = 16
) ();
  logic                          i_uart_rx;
  logic                          o_uart_tx;
  logic                          i_tx_enable;
  logic                          i_clear_err;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;
  logic                          o_overflow;
  logic                          o_parity_err;
  logic                          o_frame_err;

  modport slave (
    input  i_uart_rx, i_tx_enable, i_clear_err,
    output o_uart_tx, o_fifo_count, o_overflow, o_parity_err, o_frame_err
  );

  modport master (
    output i_uart_rx, i_tx_enable, i_clear_err,
    input  o_uart_tx, o_fifo_count, o_overflow, o_parity_err, o_frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_buffered_loopback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_buffered_loopback                                          |
// | Purpose  : UART echo: RX deserialiser -> FIFO -> TX serialiser, with       |
// |            configurable frame format, TX hold and sticky error flags.      |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module uart_buffered_loopback #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input wire                      i_clk,
  input wire                      i_reset,
  uart_buffered_loopback_if.slave bus
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  c_bit_end  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  c_half_end = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  c_data_end = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  c_stop_end = BIT_W'(STOP_BITS - 1);
  localparam logic [FCNT_W-1:0] c_full     = FCNT_W'(FIFO_DEPTH);

  localparam logic [2:0] c_rx_idle  = 3'd0;
  localparam logic [2:0] c_rx_start = 3'd1;
  localparam logic [2:0] c_rx_data  = 3'd2;
  localparam logic [2:0] c_rx_par   = 3'd3;
  localparam logic [2:0] c_rx_stop  = 3'd4;
  localparam logic [2:0] c_rx_done  = 3'd5;

  localparam logic [2:0] c_tx_idle  = 3'd0;
  localparam logic [2:0] c_tx_load  = 3'd1;
  localparam logic [2:0] c_tx_start = 3'd2;
  localparam logic [2:0] c_tx_data  = 3'd3;
  localparam logic [2:0] c_tx_par   = 3'd4;
  localparam logic [2:0] c_tx_stop  = 3'd5;

  // Odd parity makes data^par carry an odd number of ones; even the opposite.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_err_q, rx_par_err_d, rx_frm_err_q, rx_frm_err_d;

  logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]    count_q, count_d;

  logic [2:0]           tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;

  logic                 overflow_q, overflow_d, parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;

  logic w_rx_good, w_set_frm, w_set_par, w_set_ovf;
  logic w_push, w_pop, w_full, w_empty, w_tx;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= c_rx_idle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_err_q <= 1'b0;
      rx_frm_err_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tx_state_q   <= c_tx_idle;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_err_q <= rx_par_err_d;
      rx_frm_err_q <= rx_frm_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q] <= rx_shift_q;
    end
  end

  // RX next state: a start edge is the synchronised 1->0, so a line held low
  // after a bad stop bit does not retrigger.
  always_comb begin
    rx_meta_d    = bus.i_uart_rx;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_err_d = rx_par_err_q;
    rx_frm_err_d = rx_frm_err_q;
    case (rx_state_q)
      c_rx_idle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d   = c_rx_start;
          rx_cnt_d     = '0;
          rx_par_err_d = 1'b0;
          rx_frm_err_d = 1'b0;
        end
      end
      c_rx_start: begin
        if (rx_cnt_q == c_half_end) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? c_rx_idle : c_rx_data;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      c_rx_data: begin
        if (rx_cnt_q == c_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == c_data_end) begin
            rx_bit_d   = '0;
            rx_state_d = (PARITY != 0) ? c_rx_par : c_rx_stop;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      c_rx_par: begin
        if (rx_cnt_q == c_bit_end) begin
          rx_cnt_d     = '0;
          rx_bit_d     = '0;
          rx_par_err_d = (rx_sync_q != par_bit(rx_shift_q));
          rx_state_d   = c_rx_stop;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      c_rx_stop: begin
        if (rx_cnt_q == c_bit_end) begin
          rx_cnt_d = '0;
          if (!rx_sync_q) begin
            rx_frm_err_d = 1'b1;
          end
          if (rx_bit_q == c_stop_end) begin
            rx_state_d = c_rx_done;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = c_rx_idle;
    endcase
  end

  always_comb begin
    w_set_frm = (rx_state_q == c_rx_done) && rx_frm_err_q;
    w_set_par = (rx_state_q == c_rx_done) && !rx_frm_err_q && rx_par_err_q;
    w_rx_good = (rx_state_q == c_rx_done) && !rx_frm_err_q && !rx_par_err_q;
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  always_comb begin
    w_full    = (count_q == c_full);
    w_empty   = (count_q == '0);
    w_push    = w_rx_good && (!w_full || w_pop);
    w_set_ovf = w_rx_good && w_full && !w_pop;
    wr_ptr_d  = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = w_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
    overflow_d   = (overflow_q && !bus.i_clear_err) || w_set_ovf;
    parity_err_d = (parity_err_q && !bus.i_clear_err) || w_set_par;
    frame_err_d  = (frame_err_q && !bus.i_clear_err) || w_set_frm;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      c_tx_idle: begin
        if (!w_empty && bus.i_tx_enable) begin
          tx_state_d = c_tx_load;
        end
      end
      c_tx_load: begin
        tx_shift_d = fifo_mem_q[rd_ptr_q];
        tx_par_d   = par_bit(fifo_mem_q[rd_ptr_q]);
        tx_cnt_d   = '0;
        tx_state_d = c_tx_start;
      end
      c_tx_start: begin
        if (tx_cnt_q == c_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = c_tx_data;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      c_tx_data: begin
        if (tx_cnt_q == c_bit_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == c_data_end) begin
            tx_bit_d   = '0;
            tx_state_d = (PARITY != 0) ? c_tx_par : c_tx_stop;
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      c_tx_par: begin
        if (tx_cnt_q == c_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = c_tx_stop;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      c_tx_stop: begin
        if (tx_cnt_q == c_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == c_stop_end) begin
            tx_state_d = c_tx_idle;
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = c_tx_idle;
    endcase
  end

  always_comb begin
    w_pop = (tx_state_q == c_tx_load);
    case (tx_state_q)
      c_tx_start: w_tx = 1'b0;
      c_tx_data:  w_tx = tx_shift_q[0];
      c_tx_par:   w_tx = tx_par_q;
      default:    w_tx = 1'b1;
    endcase
  end

  assign bus.o_uart_tx    = w_tx;
  assign bus.o_fifo_count = count_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_parity_err = parity_err_q;
  assign bus.o_frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_buffered_loopback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_buffered_loopback                                       |
// | Purpose  : Directed bench: 8N1 depth-4 instance and 8E1 depth-16 instance. |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_uart_buffered_loopback;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_buffered_loopback_if #(.FIFO_DEPTH(4))  bus_a ();
  uart_buffered_loopback_if #(.FIFO_DEPTH(16)) bus_b ();

  uart_buffered_loopback #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (.i_clk(clk), .i_reset(rst), .bus(bus_a));

  uart_buffered_loopback #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_dut_b (.i_clk(clk), .i_reset(rst), .bus(bus_b));

  logic [7:0] mon_a_data [$];
  int         mon_a_cyc  [$];
  bit         mon_a_ok   [$];
  logic [7:0] mon_b_data [$];
  int         mon_b_cyc  [$];
  bit         mon_b_ok   [$];

  typedef struct {
    logic [7:0] data;
    bit         par_val;
    bit         stop_val;
    bit         exp_echo;
    bit         exp_par_err;
    bit         exp_frm_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic get_tx(input int w);
    return (w == 0) ? bus_a.o_uart_tx : bus_b.o_uart_tx;
  endfunction

  function automatic int mon_size(input int w);
    return (w == 0) ? mon_a_data.size() : mon_b_data.size();
  endfunction

  task automatic drive_rx(input int w, input logic v);
    if (w == 0) bus_a.i_uart_rx = v;
    else        bus_b.i_uart_rx = v;
  endtask

  // Called and returns at one time unit after a rising edge; frames are exactly back to back.
  task automatic send_frame(input int w, input logic [7:0] d, input bit has_par,
                            input bit par_v, input bit stop_v);
    drive_rx(w, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      drive_rx(w, d[i]);
      tick(CPB);
    end
    if (has_par) begin
      drive_rx(w, par_v);
      tick(CPB);
    end
    drive_rx(w, stop_v);
    tick(CPB);
    drive_rx(w, 1'b1);
  endtask

  task automatic neg_step(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Independent serial receiver on o_uart_tx; frames cut by reset are dropped.
  task automatic mon_frame(input int w);
    logic [7:0] d;
    bit         ab;
    bit         ok;
    int         st;
    d  = '0;
    ab = 1'b0;
    ok = 1'b1;
    st = cyc;
    neg_step(4, ab);
    if (get_tx(w) !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      neg_step(CPB, ab);
      d[i] = get_tx(w);
    end
    if (w == 1) begin
      neg_step(CPB, ab);
      if (get_tx(w) !== ^d) ok = 1'b0;
    end
    neg_step(CPB, ab);
    if (get_tx(w) !== 1'b1) ok = 1'b0;
    if (!ab) begin
      if (w == 0) begin
        mon_a_data.push_back(d); mon_a_cyc.push_back(st); mon_a_ok.push_back(ok);
      end else begin
        mon_b_data.push_back(d); mon_b_cyc.push_back(st); mon_b_ok.push_back(ok);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus_a.o_uart_tx === 1'b0) mon_frame(0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus_b.o_uart_tx === 1'b0) mon_frame(1);
    end
  end

  task automatic wait_mon(input int w, input int n, input int budget, input string name);
    int k;
    k = 0;
    while (mon_size(w) < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, mon_size(w), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vecs [8];
    logic [7:0] bb   [4];
    logic [7:0] ov   [6];
    int         base;
    int         k;

    vecs[0] = '{8'h53, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h53, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h61, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bb = '{8'h53, 8'h61, 8'hA5, 8'h0F};
    ov = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rst = 1'b1;
    bus_a.i_uart_rx = 1'b1; bus_a.i_tx_enable = 1'b1; bus_a.i_clear_err = 1'b0;
    bus_b.i_uart_rx = 1'b1; bus_b.i_tx_enable = 1'b1; bus_b.i_clear_err = 1'b0;
    @(posedge clk);
    #1;
    tick(3);
    check("reset_tx_a", bus_a.o_uart_tx, 1);
    check("reset_count_a", bus_a.o_fifo_count, 0);
    check("reset_flags_a", {bus_a.o_overflow, bus_a.o_parity_err, bus_a.o_frame_err}, 0);
    check("reset_tx_b", bus_b.o_uart_tx, 1);
    check("reset_flags_b", {bus_b.o_overflow, bus_b.o_parity_err, bus_b.o_frame_err}, 0);
    rst = 1'b0;
    tick(5);

    // Single 8N1 character: start bit on the second edge after the push edge.
    fork
      send_frame(0, 8'h53, 1'b0, 1'b0, 1'b1);
      begin
        k = 0;
        while (bus_a.o_fifo_count == 0 && k < 200) begin
          tick(1);
          k++;
        end
        check("lat_push_count", bus_a.o_fifo_count, 1);
        check("lat_tx_e0", bus_a.o_uart_tx, 1);
        tick(1);
        check("lat_count_e1", bus_a.o_fifo_count, 1);
        check("lat_tx_e1", bus_a.o_uart_tx, 1);
        tick(1);
        check("lat_tx_e2", bus_a.o_uart_tx, 0);
        check("lat_count_e2", bus_a.o_fifo_count, 0);
      end
    join
    wait_mon(0, 1, 300, "single_echo_seen");
    if (mon_a_data.size() >= 1) begin
      check("single_echo_data", mon_a_data[0], 8'h53);
      check("single_echo_frame", mon_a_ok[0], 1);
    end

    // Back-to-back characters, echoed in order with 82-cycle start spacing.
    tick(20);
    base = mon_a_data.size();
    for (int i = 0; i < 4; i++) send_frame(0, bb[i], 1'b0, 1'b0, 1'b1);
    wait_mon(0, base + 4, 600, "b2b_echo_seen");
    if (mon_a_data.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("b2b_data_%0d", i), mon_a_data[base + i], bb[i]);
        check($sformatf("b2b_frame_%0d", i), mon_a_ok[base + i], 1);
        if (i > 0) check($sformatf("b2b_gap_%0d", i),
                         mon_a_cyc[base + i] - mon_a_cyc[base + i - 1], 82);
      end
    end
    check("b2b_flags", {bus_a.o_overflow, bus_a.o_parity_err, bus_a.o_frame_err}, 0);

    // TX held with a depth-4 FIFO: two of six characters overflow.
    tick(20);
    base = mon_a_data.size();
    bus_a.i_tx_enable = 1'b0;
    for (int i = 0; i < 6; i++) send_frame(0, ov[i], 1'b0, 1'b0, 1'b1);
    tick(2);
    check("ovf_count", bus_a.o_fifo_count, 4);
    check("ovf_flag", bus_a.o_overflow, 1);
    check("ovf_tx_held", mon_a_data.size(), base);
    bus_a.i_tx_enable = 1'b1;
    wait_mon(0, base + 4, 600, "ovf_echo_seen");
    tick(150);
    check("ovf_echo_total", mon_a_data.size(), base + 4);
    if (mon_a_data.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("ovf_data_%0d", i), mon_a_data[base + i], ov[i]);
    end
    bus_a.i_clear_err = 1'b1;
    tick(1);
    bus_a.i_clear_err = 1'b0;
    check("ovf_cleared", bus_a.o_overflow, 0);

    // Three-cycle low glitch is rejected, then a bad stop bit is flagged and dropped.
    base = mon_a_data.size();
    drive_rx(0, 1'b0);
    tick(3);
    drive_rx(0, 1'b1);
    tick(40);
    check("glitch_count", bus_a.o_fifo_count, 0);
    check("glitch_flags", {bus_a.o_overflow, bus_a.o_parity_err, bus_a.o_frame_err}, 0);
    send_frame(0, 8'h61, 1'b0, 1'b0, 1'b0);
    tick(2);
    check("frm_flag", bus_a.o_frame_err, 1);
    check("frm_count", bus_a.o_fifo_count, 0);
    tick(100);
    check("frm_no_echo", mon_a_data.size(), base);
    bus_a.i_clear_err = 1'b1;
    tick(1);
    bus_a.i_clear_err = 1'b0;
    check("frm_cleared", bus_a.o_frame_err, 0);

    // Reset during a low data bit of 0x53 (bit 2), then a clean echo.
    send_frame(0, 8'h53, 1'b0, 1'b0, 1'b1);
    k = 0;
    while (bus_a.o_uart_tx !== 1'b0 && k < 50) begin
      tick(1);
      k++;
    end
    check("rst_tx_started", bus_a.o_uart_tx, 0);
    tick(27);
    check("rst_pre_bit2", bus_a.o_uart_tx, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_tx_high", bus_a.o_uart_tx, 1);
    check("rst_count", bus_a.o_fifo_count, 0);
    tick(150);
    base = mon_a_data.size();
    send_frame(0, 8'h53, 1'b0, 1'b0, 1'b1);
    wait_mon(0, base + 1, 300, "rst_echo_seen");
    if (mon_a_data.size() >= base + 1) begin
      check("rst_echo_data", mon_a_data[base], 8'h53);
      check("rst_echo_frame", mon_a_ok[base], 1);
    end

    // Even-parity instance driven from the vector table.
    for (int i = 0; i < 8; i++) begin
      base = mon_b_data.size();
      send_frame(1, vecs[i].data, 1'b1, vecs[i].par_val, vecs[i].stop_val);
      tick(2);
      check($sformatf("vec%0d_par_err", i), bus_b.o_parity_err, vecs[i].exp_par_err);
      check($sformatf("vec%0d_frm_err", i), bus_b.o_frame_err, vecs[i].exp_frm_err);
      if (vecs[i].exp_echo) begin
        wait_mon(1, base + 1, 300, $sformatf("vec%0d_echo_seen", i));
        if (mon_b_data.size() >= base + 1) begin
          check($sformatf("vec%0d_echo_data", i), mon_b_data[base], vecs[i].data);
          check($sformatf("vec%0d_echo_frame", i), mon_b_ok[base], 1);
        end
      end else begin
        tick(120);
        check($sformatf("vec%0d_no_echo", i), mon_b_data.size(), base);
      end
      bus_b.i_clear_err = 1'b1;
      tick(1);
      bus_b.i_clear_err = 1'b0;
      check($sformatf("vec%0d_cleared", i), {bus_b.o_parity_err, bus_b.o_frame_err}, 0);
      tick(10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
